// File: rtl/pc_secuenciador.sv
// Fetch-stage program counter: registered PC, next-PC selection with stall hold,
// branch/jump redirect buffered across stalls, and an IDLE/RUN/HALTED sequencer.
module pc_secuenciador #(
    parameter int unsigned          PC_WIDTH = 11,
    parameter int unsigned          STEP     = 1,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                halt,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [PC_WIDTH-1:0] pc_actual,
    output logic [PC_WIDTH-1:0] pc_incrementado,
    output logic                pc_valid,
    output logic                redirect_pend
);

    localparam logic [PC_WIDTH-1:0] STEP_W = PC_WIDTH'(STEP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] tgt_q, tgt_d;
    logic                pend_q, pend_d;
    logic                valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE, HALTED: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                    pend_d  = 1'b0;
                end else if (stall) begin
                    // Newest redirect seen during the stall is the one kept.
                    if (branch_taken) begin
                        tgt_d  = branch_target;
                        pend_d = 1'b1;
                    end else if (jump) begin
                        tgt_d  = jump_target;
                        pend_d = 1'b1;
                    end
                end else if (branch_taken) begin
                    pc_d   = branch_target;
                    pend_d = 1'b0;
                end else if (jump) begin
                    pc_d   = jump_target;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    pc_d   = tgt_q;
                    pend_d = 1'b0;
                end else begin
                    pc_d = pc_q + STEP_W;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
        end
    end

    assign pc_actual       = pc_q;
    assign pc_incrementado = pc_q + STEP_W;
    assign pc_valid        = valid_q;
    assign redirect_pend   = pend_q;

endmodule

// File: tb/tb_pc_secuenciador.sv
// Bench for pc_secuenciador: a STEP=1 and a STEP=4 instance share stimulus and are
// checked against a cycle model plus a hand-derived vector table and reset corners.
module tb_pc_secuenciador;

    localparam int W    = 11;
    localparam int MODV = 1 << W;
    localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2;

    logic clk = 1'b0;
    logic reset, start, halt, stall, br, jp;
    logic [W-1:0] bt, jt;
    logic [W-1:0] pc1, inc1, pc4, inc4;
    logic v1, p1, v4, p4;

    always #5 clk = ~clk;

    pc_secuenciador #(.PC_WIDTH(W), .STEP(1), .RESET_PC('0)) dut1 (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
        .branch_taken(br), .branch_target(bt), .jump(jp), .jump_target(jt),
        .pc_actual(pc1), .pc_incrementado(inc1), .pc_valid(v1), .redirect_pend(p1));

    pc_secuenciador #(.PC_WIDTH(W), .STEP(4), .RESET_PC('0)) dut4 (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
        .branch_taken(br), .branch_target(bt), .jump(jp), .jump_target(jt),
        .pc_actual(pc4), .pc_incrementado(inc4), .pc_valid(v4), .redirect_pend(p4));

    typedef struct {
        int  st;
        int  pc;
        bit  pend;
        int  tgt;
    } m_t;

    typedef struct {
        bit st, hl, sl, br;
        int bt;
        bit jp;
        int jt;
        int epc;
        bit ev, ep;
    } vec_t;

    m_t   m1, m4;
    vec_t tbl[29];
    int   n_cmp = 0, n_err = 0;

    function automatic m_t model_reset();
        m_t m;
        m.st = S_IDLE; m.pc = 0; m.pend = 0; m.tgt = 0;
        return m;
    endfunction

    function automatic m_t nxt(m_t m, int step, bit st, bit hl, bit sl, bit b,
                               int btg, bit j, int jtg);
        m_t n = m;
        if (m.st != S_RUN) begin
            if (st) n.st = S_RUN;
        end else if (hl) begin
            n.st = S_HALT; n.pend = 0;
        end else if (sl) begin
            if (b)      begin n.pend = 1; n.tgt = btg; end
            else if (j) begin n.pend = 1; n.tgt = jtg; end
        end else if (b)      begin n.pc = btg;   n.pend = 0; end
        else if (j)          begin n.pc = jtg;   n.pend = 0; end
        else if (m.pend)     begin n.pc = m.tgt; n.pend = 0; end
        else n.pc = (m.pc + step) % MODV;
        return n;
    endfunction

    function automatic vec_t mk(bit st, bit hl, bit sl, bit b, int btg, bit j, int jtg,
                                int epc, bit ev, bit ep);
        vec_t v;
        v.st = st; v.hl = hl; v.sl = sl; v.br = b; v.bt = btg; v.jp = j; v.jt = jtg;
        v.epc = epc; v.ev = ev; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_models();
        chk("pc1",   int'(pc1),  m1.pc);
        chk("inc1",  int'(inc1), (m1.pc + 1) % MODV);
        chk("vld1",  int'(v1),   int'(m1.st == S_RUN));
        chk("pend1", int'(p1),   int'(m1.pend));
        chk("pc4",   int'(pc4),  m4.pc);
        chk("inc4",  int'(inc4), (m4.pc + 4) % MODV);
        chk("vld4",  int'(v4),   int'(m4.st == S_RUN));
        chk("pend4", int'(p4),   int'(m4.pend));
    endtask

    task automatic cyc(input bit st, input bit hl, input bit sl, input bit b, input int btg,
                       input bit j, input int jtg);
        @(negedge clk);
        start = st; halt = hl; stall = sl; br = b; jp = j;
        bt = W'(btg); jt = W'(jtg);
        @(posedge clk);
        m1 = nxt(m1, 1, st, hl, sl, b, btg, j, jtg);
        m4 = nxt(m4, 4, st, hl, sl, b, btg, j, jtg);
        #1;
        check_models();
    endtask

    initial begin
        reset = 1'b1; start = 0; halt = 0; stall = 0; br = 0; jp = 0; bt = '0; jt = '0;
        m1 = model_reset(); m4 = model_reset();
        repeat (2) @(negedge clk);
        chk("rst_pc", int'(pc1), 0);
        chk("rst_inc1", int'(inc1), 1);
        chk("rst_inc4", int'(inc4), 4);
        chk("rst_vld", int'(v1), 0);
        chk("rst_pend", int'(p1), 0);
        reset = 1'b0;

        //            st hl sl br bt     jp jt      pc     v  p
        tbl[0]  = mk(1, 0, 0, 0, 0,     0, 0,     0,     1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0,     0, 0,     1,     1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0,     0, 0,     2,     1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0,     0, 0,     3,     1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0,     0, 0,     4,     1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0,     1, 'h5,   'h5,   1, 0);
        tbl[6]  = mk(0, 0, 1, 1, 'h40,  0, 0,     'h5,   1, 1);
        tbl[7]  = mk(0, 0, 1, 0, 0,     0, 0,     'h5,   1, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0,     0, 0,     'h40,  1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0,     0, 0,     'h41,  1, 0);
        tbl[10] = mk(0, 0, 0, 1, 'h10,  1, 'h20,  'h10,  1, 0);
        tbl[11] = mk(0, 0, 1, 1, 'h40,  0, 0,     'h10,  1, 1);
        tbl[12] = mk(0, 0, 0, 0, 0,     1, 'h30,  'h30,  1, 0);
        tbl[13] = mk(0, 0, 0, 0, 0,     0, 0,     'h31,  1, 0);
        tbl[14] = mk(0, 0, 1, 0, 0,     1, 'h55,  'h31,  1, 1);
        tbl[15] = mk(0, 0, 1, 1, 'h66,  0, 0,     'h31,  1, 1);
        tbl[16] = mk(0, 0, 0, 0, 0,     0, 0,     'h66,  1, 0);
        tbl[17] = mk(0, 0, 0, 0, 0,     1, 'h7,   'h7,   1, 0);
        tbl[18] = mk(0, 0, 1, 1, 'h50,  0, 0,     'h7,   1, 1);
        tbl[19] = mk(0, 1, 1, 1, 'h99,  1, 'h9,   'h7,   0, 0);
        tbl[20] = mk(0, 0, 1, 1, 'h22,  0, 0,     'h7,   0, 0);
        tbl[21] = mk(1, 0, 0, 0, 0,     0, 0,     'h7,   1, 0);
        tbl[22] = mk(0, 0, 0, 0, 0,     0, 0,     'h8,   1, 0);
        tbl[23] = mk(0, 0, 0, 0, 0,     0, 0,     'h9,   1, 0);
        tbl[24] = mk(0, 0, 0, 0, 0,     1, 'h7FC, 'h7FC, 1, 0);
        tbl[25] = mk(0, 0, 0, 0, 0,     0, 0,     'h7FD, 1, 0);
        tbl[26] = mk(0, 0, 0, 0, 0,     0, 0,     'h7FE, 1, 0);
        tbl[27] = mk(0, 0, 0, 0, 0,     0, 0,     'h7FF, 1, 0);
        tbl[28] = mk(0, 0, 0, 0, 0,     0, 0,     'h000, 1, 0);

        for (int i = 0; i < 29; i++) begin
            cyc(tbl[i].st, tbl[i].hl, tbl[i].sl, tbl[i].br, tbl[i].bt, tbl[i].jp, tbl[i].jt);
            chk($sformatf("tbl%0d_pc", i),   int'(pc1), tbl[i].epc);
            chk($sformatf("tbl%0d_vld", i),  int'(v1),  int'(tbl[i].ev));
            chk($sformatf("tbl%0d_pend", i), int'(p1),  int'(tbl[i].ep));
            if (i == 25) chk("wrap_step4", int'(pc4), 0);
        end

        // Held in HALTED for 10 cycles with noise on every non-start input.
        cyc(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom % MODV),
                1'($urandom), int'($urandom % MODV));
            chk("halted_vld", int'(v1), 0);
        end
        cyc(1, 0, 0, 0, 0, 0, 0);

        // Async reset mid-cycle with a pending redirect at PC 0x123.
        cyc(0, 0, 0, 0, 0, 1, 'h123);
        cyc(0, 0, 1, 1, 'h200, 0, 0);
        chk("pre_rst_pc", int'(pc1), 'h123);
        chk("pre_rst_pend", int'(p1), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        m1 = model_reset(); m4 = model_reset();
        chk("arst_pc", int'(pc1), 0);
        chk("arst_inc", int'(inc1), 1);
        chk("arst_vld", int'(v1), 0);
        chk("arst_pend", int'(p1), 0);
        check_models();
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 1, 1, 1, 'h77, 1, 'h66);
        chk("idle_after_rst_pc", int'(pc1), 0);
        chk("idle_after_rst_vld", int'(v1), 0);
        cyc(1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 16) == 0, ($urandom % 32) == 0, ($urandom % 4) == 0,
                ($urandom % 6) == 0, int'($urandom % MODV),
                ($urandom % 6) == 0, int'($urandom % MODV));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
